// File: rtl/vdp_vram_arb_if.sv
// ----------------------------------------------------------------------------
// vdp_vram_arb_if
// Bus bundle for the VDP VRAM arbiter: CPU-side (I/O) request/return,
// renderer fetch request/return, and the registered single-port VRAM port.
//
// Modports:
//   slave  - arbiter view (vdp_vram_arb)
//   master - environment view (I/O stage, renderer and VRAM together)
//
// Signals:
//   screenBusy            renderer in active display, renderer has priority
//   io_req/io_we/io_addr/io_wdata   CPU-side request (io_req is a 1-cycle pulse)
//   io_rdata/io_done/io_ovf         CPU-side return, completion pulse, sticky drop flag
//   rd_req/rd_addr        renderer fetch request (level)
//   rd_gnt                renderer fetch accepted this cycle (combinational)
//   rd_rdata/rd_valid     renderer fetch return
//   mem_addr/mem_wdata/mem_we/mem_re   registered VRAM port
//   mem_rdata             VRAM read data, valid the cycle after mem_re
// ----------------------------------------------------------------------------
interface vdp_vram_arb_if #(
    parameter int ADDR_W = 14
);
    logic              screenBusy;

    logic              io_req;
    logic              io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [7:0]        io_wdata;
    logic [7:0]        io_rdata;
    logic              io_done;
    logic              io_ovf;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [7:0]        rd_rdata;
    logic              rd_valid;

    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    modport slave (
        input  screenBusy,
        input  io_req, io_we, io_addr, io_wdata,
        output io_rdata, io_done, io_ovf,
        input  rd_req, rd_addr,
        output rd_gnt, rd_rdata, rd_valid,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output screenBusy,
        output io_req, io_we, io_addr, io_wdata,
        input  io_rdata, io_done, io_ovf,
        output rd_req, rd_addr,
        input  rd_gnt, rd_rdata, rd_valid,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/vdp_vram_arb.sv
// ----------------------------------------------------------------------------
// vdp_vram_arb
// VRAM access arbiter and pipeline between the VDP I/O port logic and the
// display renderer, in front of a single-port VRAM.
//
// - One-entry pending buffer for CPU-side requests (io_req pulses); a request
//   arriving while the buffer is occupied and not draining is dropped and
//   sets the sticky io_ovf flag.
// - Grant each cycle: renderer wins when screenBusy is set or nothing is
//   pending; otherwise the pending I/O access goes.
// - Issue stage registers mem_* one cycle after the grant; return stage
//   delivers rd_valid / io_done two cycles after the grant, tagged by owner.
//
// Ports:
//   clk    clock
//   rst_L  asynchronous active-low reset
//   bus    vdp_vram_arb_if.slave (all request, return and VRAM signals)
//
// Parameters:
//   ADDR_W        VRAM address width
//   STARVE_LIMIT  wait cycles before a pending I/O access is forced through
//                 (only with VDP_ARB_STARVE_GUARD_EN)
//
// Optional feature: define VDP_ARB_STARVE_GUARD_EN to enable the starvation
// guard; the default build has no counter and the renderer can hold off I/O
// indefinitely while screenBusy and rd_req stay high.
// ----------------------------------------------------------------------------
module vdp_vram_arb #(
    parameter int ADDR_W       = 14,
    parameter int STARVE_LIMIT = 32
) (
    input  logic           clk,
    input  logic           rst_L,
    vdp_vram_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_RENDER = 2'd1,
        OWN_IO_RD  = 2'd2,
        OWN_IO_WR  = 2'd3
    } owner_e;

    // Pending buffer
    logic              pend;
    logic              p_we;
    logic [ADDR_W-1:0] p_addr;
    logic [7:0]        p_wdata;
    logic              io_ovf_q;

    // Grant
    logic              render_gnt;
    logic              io_gnt;
    logic              io_capture;
    logic              force_io;

    // Issue stage
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              mem_we_q;
    logic              mem_re_q;
    owner_e            issue_tag;

    // Return stage
    owner_e            ret_tag;
    logic [7:0]        io_rdata_q;
    logic [7:0]        rd_rdata_q;
    logic [7:0]        io_rdata_d;
    logic [7:0]        rd_rdata_d;

`ifdef VDP_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            starve_cnt <= '0;
        end else if (!pend || io_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign force_io = (starve_cnt == CNT_MAX);
`else
    assign force_io = 1'b0;
`endif

    // Grant uses the registered pend, so a request can be granted no earlier
    // than the cycle after its io_req pulse.
    always_comb begin
        render_gnt = bus.rd_req & (bus.screenBusy | ~pend) & ~force_io;
        io_gnt     = pend & ~render_gnt;
        io_capture = bus.io_req & (~pend | io_gnt);
    end

    assign bus.rd_gnt = render_gnt;

    // Pending buffer and overflow flag
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            pend     <= 1'b0;
            p_we     <= 1'b0;
            p_addr   <= '0;
            p_wdata  <= '0;
            io_ovf_q <= 1'b0;
        end else begin
            if (io_capture) begin
                pend    <= 1'b1;
                p_we    <= bus.io_we;
                p_addr  <= bus.io_addr;
                p_wdata <= bus.io_wdata;
            end else if (io_gnt) begin
                pend <= 1'b0;
            end

            if (bus.io_req && !io_capture) begin
                io_ovf_q <= 1'b1;
            end
        end
    end

    // Issue stage: mem_addr / mem_wdata hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            issue_tag   <= OWN_NONE;
        end else begin
            mem_we_q  <= 1'b0;
            mem_re_q  <= 1'b0;
            issue_tag <= OWN_NONE;
            if (render_gnt) begin
                mem_addr_q <= bus.rd_addr;
                mem_re_q   <= 1'b1;
                issue_tag  <= OWN_RENDER;
            end else if (io_gnt) begin
                mem_addr_q <= p_addr;
                if (p_we) begin
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= p_wdata;
                    issue_tag   <= OWN_IO_WR;
                end else begin
                    mem_re_q  <= 1'b1;
                    issue_tag <= OWN_IO_RD;
                end
            end
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;

    // Return stage. mem_rdata is already valid in the return cycle, so the
    // data outputs pass it straight through while the tag selects them and
    // otherwise show the held copy; this keeps the two-cycle grant-to-return
    // latency without an extra register stage.
    always_comb begin
        io_rdata_d = io_rdata_q;
        rd_rdata_d = rd_rdata_q;
        if (ret_tag == OWN_IO_RD) begin
            io_rdata_d = bus.mem_rdata;
        end
        if (ret_tag == OWN_RENDER) begin
            rd_rdata_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            ret_tag    <= OWN_NONE;
            io_rdata_q <= '0;
            rd_rdata_q <= '0;
        end else begin
            ret_tag    <= issue_tag;
            io_rdata_q <= io_rdata_d;
            rd_rdata_q <= rd_rdata_d;
        end
    end

    assign bus.rd_valid = (ret_tag == OWN_RENDER);
    assign bus.io_done  = (ret_tag == OWN_IO_RD) || (ret_tag == OWN_IO_WR);
    assign bus.io_rdata = io_rdata_d;
    assign bus.rd_rdata = rd_rdata_d;
    assign bus.io_ovf   = io_ovf_q;

endmodule
